// File: rtl/debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : debounce_array
// Purpose  : Multi-channel push-button debouncer. Each channel synchronises
//            its raw button level, filters bounce with a stability counter,
//            and produces a clean level, one-cycle press/release pulses and a
//            long-press "held" level.
// Options  : DEBOUNCE_ARRAY_REPEAT_EN - when defined, pressed auto-repeats
//            every REPEAT_CYCLES cycles while held is high.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_array #(
  parameter int CHANNELS      = 5,
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2,
  parameter int LONG_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 20000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] held
);

  // Counter widths: cnt never needs to hold STABLE_CYCLES itself, hcnt must
  // hold LONG_CYCLES so it can saturate there.
  localparam int c_CNT_W  = $clog2(STABLE_CYCLES);
  localparam int c_HCNT_W = $clog2(LONG_CYCLES + 1);

  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_HCNT_W-1:0] c_HCNT_MAX = c_HCNT_W'(LONG_CYCLES);

  // State encoding: bit 1 is the debounced level, so out decodes directly.
  localparam logic [1:0] c_IDLE_LO = 2'b00;
  localparam logic [1:0] c_WAIT_HI = 2'b01;
  localparam logic [1:0] c_HI      = 2'b11;
  localparam logic [1:0] c_WAIT_LO = 2'b10;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch

      logic [SYNC_STAGES-1:0] r_sync;
      logic                   w_s;

      logic [1:0]             r_state;
      logic [1:0]             w_state_nxt;
      logic [c_CNT_W-1:0]     r_cnt;
      logic [c_CNT_W-1:0]     w_cnt_nxt;
      logic [c_HCNT_W-1:0]    r_hcnt;
      logic [c_HCNT_W-1:0]    w_hcnt_nxt;
      logic [c_HCNT_W-1:0]    w_hcnt_inc;

      logic                   r_held;
      logic                   w_held_nxt;
      logic                   r_pressed;
      logic                   w_pressed_nxt;
      logic                   r_released;
      logic                   w_released_nxt;
      logic                   w_accept_press;

      logic                   w_out;
      logic                   w_pressed_o;
      logic                   w_released_o;
      logic                   w_held_o;

      // Synchroniser chain: the last stage is the only view of the button
      // that any decision below is allowed to use.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], button[gi]};
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];

      // Saturating hold-counter increment, shared by both "out high" states.
      assign w_hcnt_inc = (r_hcnt == c_HCNT_MAX) ? r_hcnt : (r_hcnt + 1'b1);

      // State register, counters and registered output pulses/levels.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_state    <= c_IDLE_LO;
          r_cnt      <= '0;
          r_hcnt     <= '0;
          r_held     <= 1'b0;
          r_pressed  <= 1'b0;
          r_released <= 1'b0;
        end else begin
          r_state    <= w_state_nxt;
          r_cnt      <= w_cnt_nxt;
          r_hcnt     <= w_hcnt_nxt;
          r_held     <= w_held_nxt;
          r_pressed  <= w_pressed_nxt;
          r_released <= w_released_nxt;
        end
      end

      // Next-state logic: stability filtering in both directions plus the
      // long-press counter, which runs whenever the debounced level is high.
      always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hcnt_nxt     = r_hcnt;
        w_accept_press = 1'b0;
        w_released_nxt = 1'b0;
        case (r_state)
          c_IDLE_LO: begin
            w_cnt_nxt  = '0;
            w_hcnt_nxt = '0;
            if (w_s) begin
              w_state_nxt = c_WAIT_HI;
              w_cnt_nxt   = c_CNT_ONE;
            end
          end
          c_WAIT_HI: begin
            w_hcnt_nxt = '0;
            if (!w_s) begin
              // Glitch shorter than the stability window: forget it.
              w_state_nxt = c_IDLE_LO;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_CNT_LAST) begin
              w_state_nxt    = c_HI;
              w_cnt_nxt      = '0;
              w_accept_press = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          c_HI: begin
            w_hcnt_nxt = w_hcnt_inc;
            if (!w_s) begin
              w_state_nxt = c_WAIT_LO;
              w_cnt_nxt   = c_CNT_ONE;
            end else begin
              w_cnt_nxt = '0;
            end
          end
          c_WAIT_LO: begin
            if (w_s) begin
              // Release bounce: back to HI, long-press timing continues.
              w_state_nxt = c_HI;
              w_cnt_nxt   = '0;
              w_hcnt_nxt  = w_hcnt_inc;
            end else if (r_cnt == c_CNT_LAST) begin
              w_state_nxt    = c_IDLE_LO;
              w_cnt_nxt      = '0;
              w_hcnt_nxt     = '0;
              w_released_nxt = 1'b1;
            end else begin
              w_cnt_nxt  = r_cnt + 1'b1;
              w_hcnt_nxt = w_hcnt_inc;
            end
          end
          default: begin
            w_state_nxt = c_IDLE_LO;
            w_cnt_nxt   = '0;
            w_hcnt_nxt  = '0;
          end
        endcase
        // hcnt is cleared on accepted release, so held drops with it.
        w_held_nxt = (w_hcnt_nxt == c_HCNT_MAX);
      end

`ifdef DEBOUNCE_ARRAY_REPEAT_EN
      localparam int c_RCNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
      localparam logic [c_RCNT_W-1:0] c_RCNT_LAST = c_RCNT_W'(REPEAT_CYCLES - 1);

      logic [c_RCNT_W-1:0] r_rcnt;
      logic [c_RCNT_W-1:0] w_rcnt_nxt;
      logic                w_repeat;

      // Auto-repeat timer: runs only while held stays high, so a repeat can
      // never land on the same cycle as the release pulse.
      always_comb begin
        w_rcnt_nxt = '0;
        w_repeat   = 1'b0;
        if (r_held && w_held_nxt) begin
          if (r_rcnt == c_RCNT_LAST) begin
            w_repeat = 1'b1;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
      end

      // Repeat counter register.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_rcnt <= '0;
        end else begin
          r_rcnt <= w_rcnt_nxt;
        end
      end

      assign w_pressed_nxt = w_accept_press | w_repeat;
`else
      assign w_pressed_nxt = w_accept_press;
`endif

      // Output decode: level from the state encoding, pulses from registers.
      always_comb begin
        w_out        = r_state[1];
        w_pressed_o  = r_pressed;
        w_released_o = r_released;
        w_held_o     = r_held;
      end

      assign out[gi]      = w_out;
      assign pressed[gi]  = w_pressed_o;
      assign released[gi] = w_released_o;
      assign held[gi]     = w_held_o;

    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_array
// Purpose  : Directed self-checking bench for debounce_array. Honours
//            DEBOUNCE_ARRAY_REPEAT_EN to pick the expected repeat behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_array;

  localparam int CH  = 5;
  localparam int ST  = 16;
  localparam int SY  = 2;
  localparam int LG  = 64;
  localparam int RP  = 8;
  localparam int LAT = SY + ST;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] button = '0;
  logic [CH-1:0] out;
  logic [CH-1:0] pressed;
  logic [CH-1:0] released;
  logic [CH-1:0] held;

  int checks = 0;
  int errors = 0;

  debounce_array #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (ST),
    .SYNC_STAGES   (SY),
    .LONG_CYCLES   (LG),
    .REPEAT_CYCLES (RP)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .button   (button),
    .out      (out),
    .pressed  (pressed),
    .released (released),
    .held     (held)
  );

  always #5 clock = ~clock;

  // Advance n rising edges; leaves time 1 ns after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    button = '0;
    tick(10);
    checks++; if (out !== '0)      begin errors++; $display("FAIL reset_out: got %b expected %b", out, 5'b0); end
    checks++; if (pressed !== '0)  begin errors++; $display("FAIL reset_pressed: got %b expected %b", pressed, 5'b0); end
    checks++; if (released !== '0) begin errors++; $display("FAIL reset_released: got %b expected %b", released, 5'b0); end
    checks++; if (held !== '0)     begin errors++; $display("FAIL reset_held: got %b expected %b", held, 5'b0); end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_clean_press;
    int bad;
    bad = 0;
    button[0] = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      tick(1);
      if (out !== '0 || pressed !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL press_early: got %0d bad cycles expected 0", bad); end
    tick(1);
    checks++; if (out !== 5'b00001)     begin errors++; $display("FAIL press_out: got %b expected %b", out, 5'b00001); end
    checks++; if (pressed !== 5'b00001) begin errors++; $display("FAIL press_pulse: got %b expected %b", pressed, 5'b00001); end
    tick(1);
    checks++; if (pressed !== 5'b00000) begin errors++; $display("FAIL press_width: got %b expected %b", pressed, 5'b00000); end
    // Clean release of the same channel.
    bad = 0;
    button[0] = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      tick(1);
      if (out !== 5'b00001 || released !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clean_release_early: got %0d bad cycles expected 0", bad); end
    tick(1);
    checks++; if (out !== '0)           begin errors++; $display("FAIL clean_release_out: got %b expected %b", out, 5'b0); end
    checks++; if (released !== 5'b00001) begin errors++; $display("FAIL clean_release_pulse: got %b expected %b", released, 5'b00001); end
    tick(1);
    checks++; if (released !== '0)      begin errors++; $display("FAIL clean_release_width: got %b expected %b", released, 5'b0); end
  endtask

  task automatic test_simultaneous;
    button = 5'b00011;
    tick(LAT);
    checks++; if (pressed !== 5'b00011) begin errors++; $display("FAIL simul_pressed: got %b expected %b", pressed, 5'b00011); end
    checks++; if (out !== 5'b00011)     begin errors++; $display("FAIL simul_out: got %b expected %b", out, 5'b00011); end
    button = '0;
    tick(LAT);
    checks++; if (released !== 5'b00011) begin errors++; $display("FAIL simul_released: got %b expected %b", released, 5'b00011); end
    checks++; if (pressed !== '0)        begin errors++; $display("FAIL simul_excl: got %b expected %b", pressed, 5'b0); end
    tick(2);
  endtask

  task automatic test_bounce;
    int bad;
    int seg_len [4];
    logic seg_val [4];
    bad = 0;
    seg_len = '{15, 3, 15, 24};
    seg_val = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int s = 0; s < 4; s++) begin
      button[2] = seg_val[s];
      for (int k = 0; k < seg_len[s]; k++) begin
        tick(1);
        if (out !== '0 || pressed !== '0 || released !== '0) bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bounce_reject: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_release;
    int bad;
    int np;
    int nr;
    bad = 0; np = 0; nr = 0;
    button[1] = 1'b1;
    tick(LAT);
    checks++; if (pressed !== 5'b00010) begin errors++; $display("FAIL rel_press: got %b expected %b", pressed, 5'b00010); end
    button[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1); np += int'(pressed[1]); nr += int'(released[1]);
      if (out[1] !== 1'b1) bad++;
    end
    button[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1); np += int'(pressed[1]); nr += int'(released[1]);
      if (out[1] !== 1'b1) bad++;
    end
    button[1] = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      tick(1); np += int'(pressed[1]); nr += int'(released[1]);
      if (out[1] !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rel_hold_level: got %0d bad cycles expected 0", bad); end
    tick(1); np += int'(pressed[1]); nr += int'(released[1]);
    checks++; if (out[1] !== 1'b0)      begin errors++; $display("FAIL rel_out: got %b expected %b", out[1], 1'b0); end
    checks++; if (released !== 5'b00010) begin errors++; $display("FAIL rel_pulse: got %b expected %b", released, 5'b00010); end
    for (int k = 0; k < 5; k++) begin
      tick(1); np += int'(pressed[1]); nr += int'(released[1]);
    end
    checks++; if (nr != 1) begin errors++; $display("FAIL rel_count: got %0d expected 1", nr); end
    checks++; if (np != 0) begin errors++; $display("FAIL rel_no_repress: got %0d expected 0", np); end
  endtask

  task automatic test_long_press;
    int bad;
    bad = 0;
    button[3] = 1'b1;
    tick(LAT);
    checks++; if (out !== 5'b01000) begin errors++; $display("FAIL long_out: got %b expected %b", out, 5'b01000); end
    for (int k = 1; k < LG; k++) begin
      tick(1);
      if (held !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL long_early: got %0d bad cycles expected 0", bad); end
    tick(1);
    checks++; if (held !== 5'b01000) begin errors++; $display("FAIL long_held: got %b expected %b", held, 5'b01000); end
    bad = 0;
    button[3] = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      tick(1);
      if (held[3] !== 1'b1 || out[3] !== 1'b1 || released[3] !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL long_release_early: got %0d bad cycles expected 0", bad); end
    tick(1);
    checks++; if ({out[3], held[3], released[3]} !== 3'b001) begin
      errors++; $display("FAIL long_release: got out/held/rel %b expected %b", {out[3], held[3], released[3]}, 3'b001);
    end
    tick(2);
  endtask

  task automatic test_mid_reset;
    int bad;
    button[4] = 1'b1;
    tick(8);
    #2 reset = 1'b0;
    #1;
    checks++; if ({out, pressed, released, held} !== '0) begin
      errors++; $display("FAIL rst_waithi_outs: got %b expected 0", {out, pressed, released, held});
    end
    bad = 0;
    tick(3);
    #2 reset = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      tick(1);
      if (out !== '0 || pressed !== '0 || released !== '0) bad++;
    end
    tick(1);
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_waithi_redebounce: got %0d bad cycles expected 0", bad); end
    checks++; if (pressed !== 5'b10000) begin errors++; $display("FAIL rst_waithi_press: got %b expected %b", pressed, 5'b10000); end
    tick(66);
    checks++; if (held !== 5'b10000) begin errors++; $display("FAIL rst_hi_held: got %b expected %b", held, 5'b10000); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({out, pressed, released, held} !== '0) begin
      errors++; $display("FAIL rst_hi_outs: got %b expected 0", {out, pressed, released, held});
    end
    bad = 0;
    tick(3);
    #2 reset = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      tick(1);
      if (out !== '0 || pressed !== '0 || released !== '0) bad++;
    end
    tick(1);
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_hi_redebounce: got %0d bad cycles expected 0", bad); end
    checks++; if (pressed !== 5'b10000) begin errors++; $display("FAIL rst_hi_press: got %b expected %b", pressed, 5'b10000); end
    button[4] = 1'b0;
    tick(LAT + 2);
  endtask

  task automatic test_repeat;
    int bad;
    int npulse;
    int exp_pulses;
    logic exp_p;
    bad = 0; npulse = 0;
    button[0] = 1'b1;
    tick(LAT);
    checks++; if (pressed !== 5'b00001) begin errors++; $display("FAIL rep_first_press: got %b expected %b", pressed, 5'b00001); end
    for (int k = 1; k < LG; k++) begin
      tick(1);
      if (pressed !== '0 || held !== '0) bad++;
    end
    tick(1);
    checks++; if (held !== 5'b00001) begin errors++; $display("FAIL rep_held: got %b expected %b", held, 5'b00001); end
    for (int k = 1; k <= 100; k++) begin
      tick(1);
`ifdef DEBOUNCE_ARRAY_REPEAT_EN
      exp_p = ((k % RP) == 0);
`else
      exp_p = 1'b0;
`endif
      if (pressed[0] !== exp_p) bad++;
      npulse += int'(pressed[0]);
    end
`ifdef DEBOUNCE_ARRAY_REPEAT_EN
    exp_pulses = 100 / RP;
`else
    exp_pulses = 0;
`endif
    checks++; if (bad != 0) begin errors++; $display("FAIL rep_timing: got %0d bad cycles expected 0", bad); end
    checks++; if (npulse != exp_pulses) begin errors++; $display("FAIL rep_count: got %0d expected %0d", npulse, exp_pulses); end
    button[0] = 1'b0;
    tick(LAT);
    checks++; if ({out[0], held[0], released[0]} !== 3'b001) begin
      errors++; $display("FAIL rep_release: got out/held/rel %b expected %b", {out[0], held[0], released[0]}, 3'b001);
    end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_simultaneous();
    test_bounce();
    test_release();
    test_long_press();
    test_mid_reset();
    test_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
